// File: rtl/inv_round_mix.sv
// inv_round_mix: AES inverse-cipher round back-end.
// AddRoundKey on accept, then InvMixColumns one column per cycle through a shared datapath.
module inv_round_mix (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last_round,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out
);
    typedef enum logic [1:0] {IDLE, MIX, DONE} state_t;

    state_t       r_state;
    logic [127:0] r_data;
    logic [1:0]   r_col;
    logic [31:0]  w_col;
    logic [31:0]  w_mix;

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiples 9, b, d, e are built from x, 2x, 4x, 8x of each byte.
    function automatic logic [31:0] inv_mix(input logic [31:0] c);
        logic [7:0] a, x2, x4, x8;
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a     = c[31-8*i -: 8];
            x2    = xt(a);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a;
            mb[i] = x8 ^ x2 ^ a;
            md[i] = x8 ^ x4 ^ a;
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    assign w_col = r_data[32*(3-r_col) +: 32];
    assign w_mix = inv_mix(w_col);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_data    <= '0;
            r_col     <= 2'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            state_out <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_data   <= state_in ^ round_key;
                    in_ready <= 1'b0;
                    r_col    <= 2'd0;
                    if (last_round) begin
                        r_state   <= DONE;
                        out_valid <= 1'b1;
                        state_out <= state_in ^ round_key;
                    end else begin
                        r_state <= MIX;
                    end
                end
                MIX: begin
                    r_data[32*(3-r_col) +: 32] <= w_mix;
                    r_col <= r_col + 2'd1;
                    // Last column goes straight to the output so it is valid on entering DONE.
                    if (r_col == 2'd3) begin
                        r_state   <= DONE;
                        out_valid <= 1'b1;
                        state_out <= {r_data[127:32], w_mix};
                    end
                end
                DONE: if (out_ready) begin
                    r_state   <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inv_round_mix.sv
// tb_inv_round_mix: scenario tasks plus randomized traffic checked against a GF(2^8) matrix model.
module tb_inv_round_mix;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] state_in = '0;
    logic [127:0] round_key = '0;
    logic         last_round = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] state_out;

    int n_cmp = 0;
    int n_fail = 0;

    localparam logic [127:0] KAT_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] KAT_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;

    always #5 clk = ~clk;

    inv_round_mix dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .state_in(state_in), .round_key(round_key), .last_round(last_round),
        .out_valid(out_valid), .out_ready(out_ready), .state_out(state_out)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k, input logic last);
        logic [127:0] x = s ^ k;
        logic [127:0] r = '0;
        logic [7:0] coef [4];
        logic [7:0] acc;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        if (last) return x;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(coef[(j - row) & 3], x[127-8*(4*c+j) -: 8]);
                r[127-8*(4*c+row) -: 8] = acc;
            end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one input for a single accept edge, then scrambles the inputs.
    task automatic send(input logic [127:0] s, input logic [127:0] k, input logic l);
        int n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL send_ready_timeout in_ready=%b want 1", in_ready); end
        state_in = s; round_key = k; last_round = l; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        state_in = {$urandom, $urandom, $urandom, $urandom};
        round_key = {$urandom, $urandom, $urandom, $urandom};
        last_round = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (state_out !== 128'h0) begin n_fail++; $display("FAIL reset_state_out got %h want 0", state_out); end
    endtask

    task automatic test_kat();
        out_ready = 1'b1;
        send(KAT_IN, 128'h0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL kat_in_ready T+%0d got %b want 0", k, in_ready); end
            n_cmp++; if (out_valid !== (k == 5)) begin n_fail++; $display("FAIL kat_out_valid T+%0d got %b want %b", k, out_valid, k == 5); end
            if (k < 5) tick();
        end
        n_cmp++; if (state_out !== KAT_OUT) begin n_fail++; $display("FAIL kat_state_out got %h want %h", state_out, KAT_OUT); end
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL kat_in_ready T+6 got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL kat_out_valid T+6 got %b want 0", out_valid); end
    endtask

    task automatic test_key_xor();
        out_ready = 1'b1;
        send(128'h0, KAT_IN, 1'b0);
        repeat (4) tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL keyxor_out_valid got %b want 1", out_valid); end
        n_cmp++; if (state_out !== KAT_OUT) begin n_fail++; $display("FAIL keyxor_state_out got %h want %h", state_out, KAT_OUT); end
        tick();
    endtask

    task automatic test_last_round();
        logic [127:0] exp_v = 128'h00102030_40506070_8090a0b0_c0d0e0f0;
        out_ready = 1'b1;
        send(128'h00112233_44556677_8899aabb_ccddeeff, 128'h00010203_04050607_08090a0b_0c0d0e0f, 1'b1);
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL last_out_valid T+1 got %b want 1", out_valid); end
        n_cmp++; if (state_out !== exp_v) begin n_fail++; $display("FAIL last_state_out got %h want %h", state_out, exp_v); end
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL last_in_ready T+2 got %b want 1", in_ready); end
        n_cmp++; if (state_out !== exp_v) begin n_fail++; $display("FAIL last_retain got %h want %h", state_out, exp_v); end
    endtask

    task automatic test_backpressure();
        logic [127:0] s2 = {$urandom, $urandom, $urandom, $urandom};
        logic [127:0] k2 = {$urandom, $urandom, $urandom, $urandom};
        out_ready = 1'b0;
        send(KAT_IN, 128'h0, 1'b0);
        repeat (4) tick();
        state_in = s2; round_key = k2; last_round = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid stall%0d got %b want 1", k, out_valid); end
            n_cmp++; if (state_out !== KAT_OUT) begin n_fail++; $display("FAIL bp_state_out stall%0d got %h want %h", k, state_out, KAT_OUT); end
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready stall%0d got %b want 0", k, in_ready); end
            if (k == 3) out_ready = 1'b1;
            tick();
        end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_idle_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle_out_valid got %b want 0", out_valid); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_second_valid got %b want 1", out_valid); end
        n_cmp++; if (state_out !== (s2 ^ k2)) begin n_fail++; $display("FAIL bp_second_out got %h want %h", state_out, s2 ^ k2); end
        tick();
    endtask

    task automatic test_reset_mid_mix();
        out_ready = 1'b1;
        send(KAT_IN, 128'h0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmix_out_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmix_in_ready got %b want 1", in_ready); end
        n_cmp++; if (state_out !== 128'h0) begin n_fail++; $display("FAIL rstmix_state_out got %h want 0", state_out); end
        send(KAT_IN, 128'h0, 1'b0);
        repeat (3) tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmix_early_valid T+4 got %b want 0", out_valid); end
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmix_valid T+5 got %b want 1", out_valid); end
        n_cmp++; if (state_out !== KAT_OUT) begin n_fail++; $display("FAIL rstmix_result got %h want %h", state_out, KAT_OUT); end
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        state_in = KAT_IN; round_key = '0; last_round = 1'b0; in_valid = 1'b1;
        tick();
        state_in = '0;
        for (int k = 1; k <= 5; k++) begin
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_busy T+%0d in_ready=%b want 0", k, in_ready); end
            if (k < 5) tick();
        end
        n_cmp++; if (state_out !== KAT_OUT) begin n_fail++; $display("FAIL b2b_first got %h want %h", state_out, KAT_OUT); end
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_accept T+6 in_ready=%b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second_valid got %b want 1", out_valid); end
        n_cmp++; if (state_out !== 128'h0) begin n_fail++; $display("FAIL b2b_second got %h want 0", state_out); end
        tick();
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            logic [127:0] s = {$urandom, $urandom, $urandom, $urandom};
            logic [127:0] k = {$urandom, $urandom, $urandom, $urandom};
            logic l = 1'($urandom_range(0, 2) == 0);
            logic [127:0] exp_v = model(s, k, l);
            int n = 0;
            int stall = $urandom_range(0, 2);
            out_ready = 1'b0;
            send(s, k, l);
            while (!out_valid && n < 20) begin tick(); n++; end
            n_cmp++; if (out_valid !== 1'b1 || n != (l ? 0 : 4)) begin n_fail++; $display("FAIL rand%0d_latency valid=%b extra=%0d want extra=%0d", it, out_valid, n, l ? 0 : 4); end
            n_cmp++; if (state_out !== exp_v) begin n_fail++; $display("FAIL rand%0d_data got %h want %h", it, state_out, exp_v); end
            repeat (stall) tick();
            n_cmp++; if (out_valid !== 1'b1 || state_out !== exp_v) begin n_fail++; $display("FAIL rand%0d_hold valid=%b got %h want %h", it, out_valid, state_out, exp_v); end
            out_ready = 1'b1;
            tick();
            n_cmp++; if (in_ready !== 1'b1 || state_out !== exp_v) begin n_fail++; $display("FAIL rand%0d_handoff in_ready=%b got %h want %h", it, in_ready, state_out, exp_v); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_kat();
        test_key_xor();
        test_last_round();
        test_backpressure();
        test_reset_mid_mix();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/inv_round_mix.md
Name: inv_round_mix

Overview:
- Sequential AES inverse-cipher round back-end. Sits directly downstream of the inverse S-box substitution stage.
- Takes the substituted 128-bit state, performs AddRoundKey, then InvMixColumns one column per cycle. The result goes to the next decryption round (InvShiftRows) or to the cipher output.
- Uses a valid/ready handshake on both sides so the round controller can stall it.
- `last_round` skips InvMixColumns, for the final round.

Parameters:
- None. Widths are fixed by AES: state 128, column 32, byte 8.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge
- `rst`  input  1  synchronous, active-high reset
- `in_valid`  input  1  upstream presents `state_in`/`round_key`/`last_round`
- `in_ready`  output  1  block can accept a new state
- `state_in`  input  128  substituted state; byte 0 (s[0][0]) at [127:120], column-major (FIPS-197 order)
- `round_key`  input  128  round key, same byte order
- `last_round`  input  1  1 = AddRoundKey only, no InvMixColumns
- `out_valid`  output  1  `state_out` holds a finished result
- `out_ready`  input  1  downstream accepts `state_out`
- `state_out`  output  128  round result, same byte order

Behaviour:
- **Reset** (`rst`=1 at clock edge): FSM→IDLE, `in_ready`=1, `out_valid`=0, `state_out`=0, column counter=0. Reset overrides every other input, including mid-operation; a partially mixed state is discarded.
- **FSM states:** IDLE, MIX, DONE.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`&`in_ready` (cycle T): internal state register ← `state_in` XOR `round_key`; latch `last_round`.
  - If `last_round`=1 → DONE; otherwise → MIX with col=0.
- **MIX:**
  - `in_ready`=0.
  - Each cycle, replace column col (bits [127-32*col -: 32]) with InvMixColumns of that column; col increments.
  - After col=3 is processed → DONE. Exactly 4 cycles; col wraps to 0.
- **InvMixColumns per column** (a0..a3 = bytes top to bottom):
  - b0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3; the remaining rows rotate the coefficients.
  - Arithmetic is GF(2^8) with reduction polynomial 0x11B, built from repeated xtime (shift left; XOR 0x1B if bit 7 was set).
  - Purely combinational within one cycle; one column datapath is shared across the 4 cycles.
- **DONE:**
  - `out_valid`=1; `state_out` = internal register; `in_ready`=0.
  - On `out_ready`=1 → IDLE (`out_valid` drops next cycle).
  - While `out_ready`=0, `state_out` and `out_valid` are held stable indefinitely.
- **Latency:**
  - Normal round: accept at T, `out_valid` high from T+5.
  - `last_round`: `out_valid` high from T+1.
- **Throughput:** one state per 6 cycles (normal) or 2 cycles (`last_round`) with `out_ready` tied high. No overlap: `in_ready` stays low until the result has been consumed and IDLE re-entered.
- **Input sampling:** inputs are sampled only on the accept cycle. Changes to `state_in`/`round_key`/`last_round` at any other time have no effect.
- **`state_out` between results:** retains its last value after handoff (not cleared) until the next DONE; zero only after reset.
- **Simultaneous events:** `in_valid` asserted while not in IDLE is ignored (no accept); upstream must hold it.

Test Plan:
- **Known-answer vector:** `state_in`=8e4da1bc_9fdc589d_01010101_c6c6c6c6, `round_key`=0, `last_round`=0, `out_ready`=1 → `out_valid` rises at T+5 with `state_out`=db135345_f20a225c_01010101_c6c6c6c6. `in_ready`=0 from T+1 to T+5 inclusive, and `in_ready`=1 again at T+6.
- **Key XOR before mix:** `state_in`=0, `round_key`=8e4da1bc_9fdc589d_01010101_c6c6c6c6 → `state_out`=db135345_f20a225c_01010101_c6c6c6c6 at T+5.
- **Last round:** `last_round`=1, `state_in`=00112233_44556677_8899aabb_ccddeeff, `round_key`=000102030405060708090a0b0c0d0e0f → `state_out`=00102030_40506070_8090a0b0_c0d0e0f0 with `out_valid` at T+1.
- **Backpressure:** run the known-answer vector with `out_ready`=0 for 3 cycles after `out_valid` rises → `state_out` stable, `out_valid`=1, `in_ready`=0, and a new `in_valid` is not accepted. Then `out_ready`=1 → IDLE the next cycle and the new input is accepted.
- **Reset mid-MIX:** assert `rst` at T+2 of a normal round → next cycle `out_valid`=0, `in_ready`=1, `state_out`=0. A following transaction then produces the correct known-answer result with T+5 latency.
- **Back-to-back:** two transactions (the known-answer vector, then all-zero state/key) with `out_ready` high → second accept at T+6, outputs db135345_f20a225c_01010101_c6c6c6c6 then 0, with no corruption between them.
